pixel_line_cache: RTL

PIXEL_LINE_CACHE -- requirements
Module: pixel_line_cache

---
 rtl/pixel_cache_pkg.sv | 21 ++
 rtl/pixel_word_extract.sv | 21 ++
 rtl/pixel_line_cache.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pixel_cache_pkg.sv
// Shared types and helpers for the pixel line cache: FSM states, memory word
// width and the pixel-coordinate to word-address mapping.
package pixel_cache_pkg;

  localparam int unsigned WORD_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_RESP
  } state_t;

  function automatic logic [31:0] word_addr(input logic [9:0] x,
                                            input logic [9:0] y,
                                            input int unsigned width,
                                            input int unsigned ppw);
    return 32'(y) * (width / ppw) + 32'(x) / ppw;
  endfunction

endpackage

// File: rtl/pixel_word_extract.sv
// Selects one BPP-wide pixel out of a memory word, LSB-first by column.
module pixel_word_extract
  import pixel_cache_pkg::*;
#(
  parameter int unsigned BPP = 1
) (
  input  logic [WORD_BITS-1:0] word,
  input  logic [9:0]           x,
  output logic [BPP-1:0]       pixel
);

  localparam int unsigned PPW = WORD_BITS / BPP;

  logic [WORD_BITS-1:0] shifted;

  always_comb begin
    shifted = word >> ((32'(x) % PPW) * BPP);
    pixel   = shifted[BPP-1:0];
  end

endmodule

// File: rtl/pixel_line_cache.sv
// Small fully-associative word cache in front of a fixed-latency frame memory,
// answering one pixel lookup at a time.
module pixel_line_cache
  import pixel_cache_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned BPP        = 1,
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned PPW = WORD_BITS / BPP,
  localparam int unsigned AW  = $clog2(WIDTH * HEIGHT / PPW)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [9:0]           req_x,
  input  logic [9:0]           req_y,
  input  logic                 flush,
  output logic                 rsp_valid,
  output logic [BPP-1:0]       rsp_pixel,
  output logic                 rsp_oob,
  output logic [AW-1:0]        rdaddress,
  input  logic [WORD_BITS-1:0] rdata
);

  localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  state_t               state, state_next;
  logic [9:0]           x_q, y_q;
  logic [AW-1:0]        addr;
  logic                 oob, hit, accept;
  logic [WORD_BITS-1:0] hit_data, sel_word;
  logic [BPP-1:0]       pixel;
  logic [ENTRIES-1:0]   valid;
  logic [AW-1:0]        tag  [ENTRIES];
  logic [WORD_BITS-1:0] data [ENTRIES];
  logic [IW-1:0]        rr_ptr, victim;
  logic                 any_invalid;
  logic [2:0]           fill_cnt;
  logic                 fill_last, fill_flushed, install;

  assign req_ready = (state == S_IDLE) && !flush && !reset;
  assign accept    = req_valid && req_ready;
  assign addr      = AW'(word_addr(x_q, y_q, WIDTH, PPW));
  assign oob       = (32'(x_q) >= WIDTH) || (32'(y_q) >= HEIGHT);
  assign fill_last = (state == S_FILL) && (32'(fill_cnt) == RD_LATENCY);
  // A flush seen at any point of the fill, including its final edge, blocks the install.
  assign install   = fill_last && !fill_flushed && !flush;
  assign sel_word  = (state == S_FILL) ? rdata : hit_data;

  pixel_word_extract #(.BPP(BPP)) u_extract (
    .word  (sel_word),
    .x     (x_q),
    .pixel (pixel)
  );

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == addr) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

  always_comb begin
    any_invalid = 1'b0;
    victim      = rr_ptr;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!valid[i] && !any_invalid) begin
        any_invalid = 1'b1;
        victim      = IW'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_LOOKUP;
      S_LOOKUP: state_next = (hit || oob) ? S_RESP : S_FILL;
      S_FILL:   if (fill_last) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      valid        <= '0;
      rr_ptr       <= '0;
      rsp_valid    <= 1'b0;
      rsp_pixel    <= '0;
      rsp_oob      <= 1'b0;
      rdaddress    <= '0;
      fill_cnt     <= '0;
      fill_flushed <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= 1'b0;
      rsp_pixel <= '0;
      rsp_oob   <= 1'b0;
      if (accept) begin
        x_q <= req_x;
        y_q <= req_y;
      end
      if (state == S_LOOKUP) begin
        if (oob) begin
          rsp_valid <= 1'b1;
          rsp_oob   <= 1'b1;
        end else if (hit) begin
          rsp_valid <= 1'b1;
          rsp_pixel <= pixel;
        end else begin
          rdaddress    <= addr;
          fill_cnt     <= '0;
          fill_flushed <= flush;
        end
      end
      if (state == S_FILL) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (flush) fill_flushed <= 1'b1;
        if (fill_last) begin
          rsp_valid <= 1'b1;
          rsp_pixel <= pixel;
        end
      end
      if (install) begin
        valid[victim] <= 1'b1;
        if (!any_invalid)
          rr_ptr <= (32'(rr_ptr) == ENTRIES - 1) ? '0 : rr_ptr + 1'b1;
      end
      if (flush) valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tag[victim]  <= addr;
      data[victim] <= rdata;
    end
  end

endmodule
